// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the gshare branch predictor:
//   - pcsrc_e   : fetch-mux select encodings driven on PCSrc
//   - CTR_*     : 2-bit saturating counter states
//   - OP_CTRL   : F-stage opcode class of a control-flow instruction
//   - sat_update: one saturating step of a 2-bit counter toward an outcome
// ---------------------------------------------------------------------------
package bp_pkg;

  typedef enum logic [1:0] {
    PCSRC_PLUS4F  = 2'b00,  // sequential fetch
    PCSRC_PREDF   = 2'b01,  // predicted-taken target from the BTB
    PCSRC_PLUS4E  = 2'b10,  // rollback: branch was predicted taken but fell through
    PCSRC_TARGETE = 2'b11   // rollback: computed target from E
  } pcsrc_e;

  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  localparam logic [1:0] OP_CTRL = 2'b11;

  // Move a counter one step toward the resolved outcome, holding at the ends.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] next;
    next = ctr;
    if (taken && ctr != CTR_ST) begin
      next = ctr + 2'd1;
    end else if (!taken && ctr != CTR_SNT) begin
      next = ctr - 2'd1;
    end
    return next;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// ---------------------------------------------------------------------------
// bp_pht
// Pattern history table: 2**IDX_W two-bit saturating counters.
//   clk, reset   : core clock, synchronous active-high reset (all -> CTR_RESET)
//   i_rd_idx     : asynchronous read index
//   o_rd_ctr     : counter at i_rd_idx (value before any same-edge write)
//   i_wr_en      : train the counter at i_wr_idx on this edge
//   i_wr_idx     : training index
//   i_wr_taken   : resolved outcome to saturate toward
// ---------------------------------------------------------------------------
module bp_pht
  import bp_pkg::*;
#(
  parameter int         IDX_W     = 6,
  parameter logic [1:0] CTR_RESET = CTR_WNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_ctr,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0] r_pht [DEPTH];

  // Read straight from the registers, so a same-cycle write is not seen yet.
  assign o_rd_ctr = r_pht[i_rd_idx];

  // NOTE: the table is a resettable flop bank rather than a RAM macro, so every
  // counter can be forced to a known state; a plain RAM would power up random.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        r_pht[i] <= CTR_RESET;
      end
    end else if (i_wr_en) begin
      r_pht[i_wr_idx] <= sat_update(r_pht[i_wr_idx], i_wr_taken);
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// branch_predictor_gshare
// Gshare direction predictor plus fetch-mux select with E-stage rollback.
// The PHT is indexed by PCF XOR the global history register (GHR). F gets a
// zero-latency taken prediction; E resolution trains the PHT and, on a
// mispredict, repairs the GHR from the snapshot carried down the pipe.
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   StallF            fetch stall, blocks the speculative GHR shift
//   OpF               F opcode class (2'b11 = control flow)
//   PCF               PC[IDX_W+1:2] of the fetched instruction
//   TargetHitF        BTB holds a target for PCF
//   PCSrcPredF        F-stage taken prediction
//   IdxF, GhrF        PHT index and pre-shift GHR, carried to E
//   PCSrcPredE, IdxE, GhrE   values carried back from E
//   BranchOpEb0       E instruction is a conditional branch (trains PHT)
//   TargetMatchE      predicted target equals computed target
//   PCSrcResE         resolved taken outcome
//   PCSrc             fetch-mux select (see bp_pkg::pcsrc_e)
//   MispredictE       rollback in progress, drives the D/E flush
//
// Optional build macro BP_STATS_EN adds saturating 32-bit counters
// BranchCount and MispredCount as extra outputs.
// ---------------------------------------------------------------------------
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int         IDX_W     = 6,
  parameter int         GHR_W     = 6,
  parameter logic [1:0] CTR_RESET = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic [1:0]       OpF,
  input  logic [IDX_W-1:0] PCF,
  input  logic             TargetHitF,
  output logic             PCSrcPredF,
  output logic [IDX_W-1:0] IdxF,
  output logic [GHR_W-1:0] GhrF,
  input  logic             PCSrcPredE,
  input  logic [IDX_W-1:0] IdxE,
  input  logic [GHR_W-1:0] GhrE,
  input  logic             BranchOpEb0,
  input  logic             TargetMatchE,
  input  logic             PCSrcResE,
  output logic [1:0]       PCSrc,
  output logic             MispredictE
`ifdef BP_STATS_EN
  ,
  output logic [31:0]      BranchCount,
  output logic [31:0]      MispredCount
`endif
);

  // History must fit in the index, and the shift needs at least two bits.
  if (GHR_W > IDX_W || GHR_W < 2) begin : g_bad_cfg
    $error("branch_predictor_gshare: GHR_W must be in [2, IDX_W]");
  end

  logic [GHR_W-1:0] r_ghr;
  logic [IDX_W-1:0] w_idx_f;
  logic [1:0]       w_ctr_f;
  logic             w_ctrl_f;
  logic             w_pred_f;
  logic             w_mispredict;
  pcsrc_e           w_pcsrc;

  assign w_idx_f  = PCF ^ IDX_W'(r_ghr);
  assign w_ctrl_f = (OpF == OP_CTRL);
  // Gated by reset so the prediction drops in the reset cycle itself,
  // before the table has been cleared.
  assign w_pred_f = ~reset & w_ctr_f[1] & TargetHitF & w_ctrl_f;

  bp_pht #(
    .IDX_W     (IDX_W),
    .CTR_RESET (CTR_RESET)
  ) u_pht (
    .clk        (clk),
    .reset      (reset),
    .i_rd_idx   (w_idx_f),
    .o_rd_ctr   (w_ctr_f),
    .i_wr_en    (BranchOpEb0),
    .i_wr_idx   (IdxE),
    .i_wr_taken (PCSrcResE)
  );

  // Rollback decode. A taken/taken branch only rolls back when the BTB
  // target was wrong; direction mismatches always roll back.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    w_mispredict = 1'b0;
    w_pcsrc      = w_pred_f ? PCSRC_PREDF : PCSRC_PLUS4F;
    if (BranchOpEb0 && PCSrcPredE && PCSrcResE && !TargetMatchE) begin
      w_mispredict = 1'b1;
      w_pcsrc      = PCSRC_TARGETE;
    end else if (PCSrcPredE && !PCSrcResE) begin
      w_mispredict = 1'b1;
      w_pcsrc      = PCSRC_PLUS4E;
    end else if (!PCSrcPredE && PCSrcResE) begin
      w_mispredict = 1'b1;
      w_pcsrc      = PCSRC_TARGETE;
    end
  end

  // GHR: repair from the E snapshot wins over the speculative F shift,
  // and ignores StallF because the younger fetch is being flushed anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ghr <= '0;
    end else if (w_mispredict) begin
      r_ghr <= {GhrE[GHR_W-2:0], PCSrcResE};
    end else if (w_ctrl_f && !StallF) begin
      r_ghr <= {r_ghr[GHR_W-2:0], w_pred_f};
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (BranchOpEb0 && r_branch_cnt != 32'hFFFF_FFFF) begin
        r_branch_cnt <= r_branch_cnt + 32'd1;
      end
      if (w_mispredict && r_mispred_cnt != 32'hFFFF_FFFF) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  assign BranchCount  = r_branch_cnt;
  assign MispredCount = r_mispred_cnt;
`endif

  assign PCSrcPredF  = w_pred_f;
  assign IdxF        = w_idx_f;
  assign GhrF        = r_ghr;
  assign PCSrc       = w_pcsrc;
  assign MispredictE = w_mispredict;

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
Parametrised successor to the pipeline's branch control logic. Adds a gshare direction predictor: a pattern history table (PHT) of 2-bit saturating counters, indexed by PC XOR a global history register (GHR). Produces the F-stage taken prediction and the PCSrc fetch-mux select, including E-stage rollback. Trains the PHT and repairs the GHR at E-stage resolution. Sits between fetch and the hazard unit, alongside the branch target buffer.

Parameters:
IDX_W, 6, PHT index width; PHT depth = 2**IDX_W entries.
GHR_W, 6, global history length; must be <= IDX_W (elaboration error otherwise).
CTR_RESET, 2'b01, PHT counter reset value (weakly not-taken).

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
StallF  in  1  fetch stall; blocks the speculative GHR shift
OpF  in  2  F-stage opcode class; 2'b11 = control-flow instruction
PCF  in  IDX_W  PCF[IDX_W+1:2]
TargetHitF  in  1  BTB holds a target for PCF
PCSrcPredF  out  1  F-stage taken prediction
IdxF  out  IDX_W  PHT index used at F; piped to E
GhrF  out  GHR_W  GHR value before the F shift; piped to E
PCSrcPredE  in  1  prediction carried to E
IdxE  in  IDX_W  carried index
GhrE  in  GHR_W  carried GHR snapshot
BranchOpEb0  in  1  E-stage instruction is a conditional branch
TargetMatchE  in  1  predicted target equals computed target
PCSrcResE  in  1  actual taken outcome
PCSrc  out  2  00 PCPlus4F, 01 PredPCTargetF, 11 PCTargetE, 10 PCPlus4E
MispredictE  out  1  rollback active; drives the D/E flush

Behaviour:
- Index: IdxF = PCF ^ {(IDX_W-GHR_W)'0, GHR}.
- PHT read is combinational from registered state.
- PCSrcPredF = PHT[IdxF][1] & TargetHitF & (OpF==2'b11).
- GHR speculative update: on OpF==2'b11 & ~StallF & ~MispredictE, GHR <= {GHR[GHR_W-2:0], PCSrcPredF}.
- MispredictE and rollback PCSrc:
  - BranchOpEb0 & PCSrcPredE & PCSrcResE & ~TargetMatchE -> PCSrc 11.
  - PCSrcPredE & ~PCSrcResE -> PCSrc 10.
  - ~PCSrcPredE & PCSrcResE -> PCSrc 11.
  - Otherwise PCSrc = PCSrcPredF ? 01 : 00, and MispredictE = 0.
- GHR repair: on MispredictE, GHR <= {GhrE[GHR_W-2:0], PCSrcResE}. Repair has priority over any F shift in the same cycle. Stall is ignored for repair.
- PHT training: when BranchOpEb0, PHT[IdxE] saturates toward PCSrcResE (+1 capped at 11, -1 floored at 00). Write occurs at the clock edge.
- Same-cycle read/write of the same index: F sees the pre-write value.
- Reset (synchronous, any cycle, including mid-mispredict):
  - GHR <= 0; all PHT entries <= CTR_RESET.
  - Outputs follow combinationally: PCSrcPredF=0, PCSrc=00 unless E inputs signal rollback.
  - No training or repair happens on a reset cycle.
- Latency: prediction has 0-cycle latency at F; training and repair are visible the cycle after E resolution.

Optional Feature:
BP_STATS_EN:
- Defined: adds 32-bit counters BranchCount (increments on BranchOpEb0) and MispredCount (increments on MispredictE), exposed as output ports. Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package bp_pkg holds: PCSrc encodings (PCSRC_PLUS4F, PCSRC_PREDF, PCSRC_TARGETE, PCSRC_PLUS4E), the CTR_* counter-state constants, and the sat_update function.
- One sub-module: bp_pht, the PHT array (one async read port, one sync write port, synchronous reset), instantiated once.

Test Plan:
- Reset, then OpF=11, TargetHitF=1, PCF=0x05, GHR=0 -> PCSrcPredF=0, PCSrc=00, IdxF=0x05.
- Train IdxE=0x05 taken twice (BranchOpEb0=1, PCSrcResE=1, PCSrcPredE=0) -> MispredictE=1, PCSrc=11 in the first cycle. Then counter=11, and with PCF=0x05 and GHR restored to 0, PCSrcPredF=1 and PCSrc=01.
- Counter at 11, four more taken trainings -> stays 11; counter at 00, not-taken training -> stays 00.
- PCSrcPredE=1, PCSrcResE=0, GhrE=6'b101010 -> PCSrc=10, GHR next = 6'b010100. A concurrent F shift is dropped.
- StallF=1 with OpF=11 for 3 cycles -> GHR unchanged. PCSrcPredE=1, PCSrcResE=1, BranchOpEb0=1, TargetMatchE=0 -> PCSrc=11.
- Reset asserted during a mispredict cycle -> GHR=0 and PHT[IdxE] remains CTR_RESET the next cycle.
